dmux_scan_ctrl: RTL and testbench
=================================

DMUX_SCAN_CTRL -- requirements
Module: dmux_scan_ctrl

Interface
REQ-001 Parameter DWELL, default 4: cycles each enabled channel is held selected; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  one-cycle request to begin a scan pass.
REQ-005 stop  input  1  abort the current scan.
REQ-006 mask  input  8  channel enable mask, bit n enables output n.
REQ-007 i  input  1  serial data bit to be demultiplexed.
REQ-008 sel  output  3  current demux select, registered.
REQ-009 y  output  8  demultiplexed outputs.
REQ-010 busy  output  1  high while a scan is in progress, registered.
REQ-011 done  output  1  one-cycle pulse at scan completion, registered.

Function
REQ-012 FSM states SHALL be IDLE and ACTIVE; reset state IDLE.
REQ-013 IDLE: start=1 with mask!=0 SHALL latch mask, load sel with the lowest enabled index, clear the dwell counter, set busy=1 and enter ACTIVE on the same edge.
REQ-014 IDLE: start=1 with mask==0 SHALL stay IDLE and pulse done for one cycle after that edge; busy stays 0.
REQ-015 ACTIVE: each selected channel SHALL remain on sel for exactly DWELL cycles, counted with a dwell counter that is at least 8 bits wide.
REQ-016 When dwell expires, sel SHALL advance to the next higher enabled index in the latched mask; disabled indices are skipped with no dead cycles.
REQ-017 When dwell expires on the highest enabled index, the block SHALL clear busy, pulse done for one cycle and return to IDLE; REQ-025 gives the exception.
REQ-018 y SHALL be combinational: y[sel]=i when busy=1; all other bits are 0; y=8'h00 when busy=0.
REQ-019 start during ACTIVE SHALL be ignored; mask changes during ACTIVE SHALL have no effect.
REQ-020 stop=1 in ACTIVE SHALL return to IDLE at the next edge with busy=0, sel=0 and no done pulse. stop has priority over dwell expiry, and stop in IDLE has no effect.
REQ-021 Given start on edge k, the first enabled channel SHALL drive y from cycle k+1.

Reset
REQ-022 With rst_n=0 at a rising edge, the block SHALL enter IDLE with sel=3'b000, busy=0, done=0 and the dwell counter and latched mask cleared. y is then 8'h00.
REQ-023 Reset during ACTIVE SHALL abort the scan with no done pulse. Reset has priority over start and stop.

Configuration
REQ-024 Macro DMUX_SCAN_CONT_EN SHALL select continuous scanning.
REQ-025 With the macro defined, dwell expiry on the highest enabled index SHALL wrap sel to the lowest enabled index and pulse done once per completed pass with busy held high. Only stop or reset ends the scan.
REQ-026 With the macro undefined, single-pass behaviour per REQ-017 applies and no continuous-mode logic is present.

Verification
REQ-027 DWELL=4, mask=8'hFF, i=1, start pulse -> sel steps 0..7, each held 4 cycles, y one-hot following sel; done pulses once 32 cycles after start; busy falls with it.
REQ-028 DWELL=2, mask=8'b1010_0100 -> sel sequence 2,5,7, each held 2 cycles; y[2], y[5], y[7] track i; all other y bits stay 0; done after 6 cycles.
REQ-029 mask=8'h00, start -> busy stays 0, single done pulse, y=8'h00 throughout.
REQ-030 mask=8'hFF, stop asserted while sel=3, then start asserted while busy -> busy=0, sel=0 next edge, no done; the ignored start produces no change.
REQ-031 rst_n=0 while sel=5 in ACTIVE -> next edge sel=0, busy=0, done=0, y=8'h00.
REQ-032 With DMUX_SCAN_CONT_EN defined, mask=8'b0000_0011, DWELL=1 -> sel 0,1,0,1,...; done pulses every 2 cycles; busy stays high until stop.

Source files
------------

// File: rtl/dmux_scan_ctrl.sv
// Scanning 1-to-8 demultiplexer: steps sel through the enabled channels of a latched mask, DWELL cycles each.
// Define DMUX_SCAN_CONT_EN to wrap back to the first channel instead of stopping after one pass.
module dmux_scan_ctrl #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] mask,
  input  logic       i,
  output logic [2:0] sel,
  output logic [7:0] y,
  output logic       busy,
  output logic       done
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_t     r_state;
  logic [2:0] r_sel;
  logic       r_busy;
  logic       r_done;
  logic [7:0] r_cnt;
  logic [7:0] r_mask;

  logic [2:0] w_next_sel;
  logic       w_has_next;
  logic       w_dwell_end;

  function automatic logic [2:0] lowest_idx(input logic [7:0] m);
    lowest_idx = 3'd0;
    for (int n = 7; n >= 0; n--) begin
      if (m[n]) lowest_idx = 3'(n);
    end
  endfunction

  // Scanning downwards leaves the closest enabled index above r_sel.
  always_comb begin
    w_next_sel = 3'd0;
    w_has_next = 1'b0;
    for (int n = 7; n >= 0; n--) begin
      if (r_mask[n] && (n > int'(r_sel))) begin
        w_next_sel = 3'(n);
        w_has_next = 1'b1;
      end
    end
  end

  assign w_dwell_end = (r_cnt == DWELL_LAST);

`ifdef DMUX_SCAN_CONT_EN
  logic [2:0] w_first_sel;
  assign w_first_sel = lowest_idx(r_mask);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= 3'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= 8'd0;
      r_mask  <= 8'd0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (start) begin
          if (mask != 8'd0) begin
            r_mask  <= mask;
            r_sel   <= lowest_idx(mask);
            r_cnt   <= 8'd0;
            r_busy  <= 1'b1;
            r_state <= ACTIVE;
          end else begin
            r_done <= 1'b1;
          end
        end
      end else begin
        // stop outranks dwell expiry, so an abort never produces done.
        if (stop) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_sel   <= 3'd0;
          r_cnt   <= 8'd0;
        end else if (w_dwell_end) begin
          r_cnt <= 8'd0;
          if (w_has_next) begin
            r_sel <= w_next_sel;
          end else begin
`ifdef DMUX_SCAN_CONT_EN
            r_sel  <= w_first_sel;
            r_done <= 1'b1;
`else
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_sel   <= 3'd0;
            r_done  <= 1'b1;
`endif
          end
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_y
    assign y[gi] = r_busy & i & (r_sel == 3'(gi));
  end

  assign sel  = r_sel;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_dmux_scan_ctrl.sv
// Scoreboard bench for dmux_scan_ctrl: three instances (DWELL 4, 2, 1) driven with directed scans.
// Expectations follow single-pass mode unless DMUX_SCAN_CONT_EN is defined.
module tb_dmux_scan_ctrl;

  localparam int D4 = 0;
  localparam int D2 = 1;
  localparam int D1 = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_v [3];
  logic       stop_v  [3];
  logic       i_v     [3];
  logic [7:0] mask_v  [3];
  logic [2:0] sel_v   [3];
  logic [7:0] y_v     [3];
  logic       busy_v  [3];
  logic       done_v  [3];

  always #5 clk = ~clk;

  dmux_scan_ctrl #(.DWELL(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .stop(stop_v[0]), .mask(mask_v[0]),
    .i(i_v[0]), .sel(sel_v[0]), .y(y_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  dmux_scan_ctrl #(.DWELL(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .stop(stop_v[1]), .mask(mask_v[1]),
    .i(i_v[1]), .sel(sel_v[1]), .y(y_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  dmux_scan_ctrl #(.DWELL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .stop(stop_v[2]), .mask(mask_v[2]),
    .i(i_v[2]), .sel(sel_v[2]), .y(y_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  typedef struct {
    int         dut;
    logic [2:0] sel;
    bit         sel_dc;
    logic [7:0] y;
    logic       busy;
    logic       done;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] pat = 8'b0110_1101;

  // Drive one cycle of inputs and queue what the outputs must be right after the next edge.
  task automatic step(input int d, input bit st, input bit sp, input logic [7:0] m, input bit di,
                      input bit rn, input logic [2:0] es, input bit dc, input bit eb, input bit ed,
                      input string tag);
    exp_t e;
    @(negedge clk);
    rst_n = rn;
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0;
      stop_v[k]  = 1'b0;
    end
    start_v[d] = st;
    stop_v[d]  = sp;
    mask_v[d]  = m;
    i_v[d]     = di;
    e.dut    = d;
    e.sel    = es;
    e.sel_dc = dc;
    e.busy   = eb;
    e.done   = ed;
    e.tag    = tag;
    e.y      = eb ? (8'(di) << es) : 8'h00;
    sb.push_back(e);
  endtask

  task automatic finish_pass(input int d, input logic [2:0] first, input logic [7:0] m,
                             input bit di, input string tag);
`ifdef DMUX_SCAN_CONT_EN
    step(d, 0, 0, m, di, 1, first, 0, 1, 1, {tag, "_wrap"});
    step(d, 0, 1, m, di, 1, 3'd0, 0, 0, 0, {tag, "_stop"});
`else
    step(d, 0, 0, m, di, 1, first, 1, 0, 1, {tag, "_done"});
    step(d, 0, 0, m, di, 1, 3'd0, 1, 0, 0, {tag, "_after"});
`endif
  endtask

  // Monitor: one queued expectation per rising edge, sampled 1 time unit later.
  initial begin
    exp_t       e;
    logic [2:0] a_sel;
    logic [7:0] a_y;
    logic       a_busy, a_done;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e      = sb.pop_front();
        a_sel  = sel_v[e.dut];
        a_y    = y_v[e.dut];
        a_busy = busy_v[e.dut];
        a_done = done_v[e.dut];
        n_checks++;
        if ((!e.sel_dc && a_sel !== e.sel) || a_y !== e.y || a_busy !== e.busy || a_done !== e.done) begin
          n_fail++;
          $display("FAIL %s dut%0d: got sel=%0d y=%h busy=%b done=%b, want sel=%0d%s y=%h busy=%b done=%b",
                   e.tag, e.dut, a_sel, a_y, a_busy, a_done, e.sel, e.sel_dc ? "(any)" : "",
                   e.y, e.busy, e.done);
        end else begin
          $display("[%0t] %s dut%0d sel=%0d y=%h busy=%b done=%b",
                   $time, e.tag, e.dut, a_sel, a_y, a_busy, a_done);
        end
      end
    end
  end

  initial begin
    int chs[6];
    chs = '{2, 2, 5, 5, 7, 7};
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0;
      stop_v[k]  = 1'b0;
      i_v[k]     = 1'b0;
      mask_v[k]  = 8'h00;
    end

    for (int d = 0; d < 3; d++) step(d, 0, 0, 8'h00, 1, 0, 3'd0, 0, 0, 0, "reset");
    step(D4, 0, 0, 8'h00, 1, 1, 3'd0, 0, 0, 0, "idle");

    // Full mask, DWELL=4: 0..7 with 4 cycles each, done 32 cycles after start.
    step(D4, 1, 0, 8'hFF, 1, 1, 3'd0, 0, 1, 0, "A_start");
    for (int j = 1; j < 32; j++) step(D4, 0, 0, 8'hFF, 1, 1, 3'(j / 4), 0, 1, 0, "A_scan");
    finish_pass(D4, 3'd0, 8'hFF, 1, "A");

    // Sparse mask, DWELL=2: channels 2,5,7 with varying serial data.
    step(D2, 1, 0, 8'hA4, pat[0], 1, 3'(chs[0]), 0, 1, 0, "B_start");
    for (int j = 1; j < 6; j++) step(D2, 0, 0, 8'hA4, pat[j], 1, 3'(chs[j]), 0, 1, 0, "B_scan");
    finish_pass(D2, 3'd2, 8'hA4, pat[6], "B");

    // stop on the very edge where the last dwell expires: no done.
    step(D2, 1, 0, 8'hA4, pat[1], 1, 3'(chs[0]), 0, 1, 0, "B2_start");
    for (int j = 1; j < 6; j++) step(D2, 0, 0, 8'hA4, pat[j + 1], 1, 3'(chs[j]), 0, 1, 0, "B2_scan");
    step(D2, 0, 1, 8'hA4, 1, 1, 3'd0, 0, 0, 0, "B2_stop_at_expiry");
    step(D2, 0, 0, 8'hA4, 1, 1, 3'd0, 0, 0, 0, "B2_after");

    // Empty mask: done pulse only.
    step(D4, 1, 0, 8'h00, 1, 1, 3'd0, 1, 0, 1, "C_zero_mask");
    step(D4, 0, 0, 8'h00, 1, 1, 3'd0, 1, 0, 0, "C_after");
    step(D4, 0, 0, 8'h00, 1, 1, 3'd0, 1, 0, 0, "C_idle");

    // Ignored start + mask change mid-scan, then stop (with start) while sel=3.
    step(D4, 1, 0, 8'hFF, pat[0], 1, 3'd0, 0, 1, 0, "D_start");
    for (int j = 1; j < 14; j++)
      step(D4, j == 5, 0, (j >= 5) ? 8'h01 : 8'hFF, pat[j % 8], 1, 3'(j / 4), 0, 1, 0, "D_scan");
    step(D4, 1, 1, 8'h01, pat[6], 1, 3'd0, 0, 0, 0, "D_stop");
    step(D4, 0, 1, 8'hFF, 1, 1, 3'd0, 0, 0, 0, "D_stop_idle");
    step(D4, 0, 1, 8'hFF, 1, 1, 3'd0, 0, 0, 0, "D_stop_idle");

    // Reset while sel=5, with start held: reset wins.
    step(D4, 1, 0, 8'hFF, 1, 1, 3'd0, 0, 1, 0, "E_start");
    for (int j = 1; j < 22; j++) step(D4, 0, 0, 8'hFF, 1, 1, 3'(j / 4), 0, 1, 0, "E_scan");
    step(D4, 1, 0, 8'hFF, 1, 0, 3'd0, 0, 0, 0, "E_reset");
    step(D4, 1, 0, 8'hFF, 1, 0, 3'd0, 0, 0, 0, "E_reset_start");
    step(D4, 0, 0, 8'hFF, 1, 1, 3'd0, 0, 0, 0, "E_after");

    // DWELL=1 with two channels.
    step(D1, 1, 0, 8'h03, 1, 1, 3'd0, 0, 1, 0, "F_start");
`ifdef DMUX_SCAN_CONT_EN
    for (int j = 1; j < 6; j++)
      step(D1, 0, 0, 8'h03, 1, 1, 3'(j % 2), 0, 1, (j >= 2) && (j % 2 == 0), "F_cont");
    step(D1, 0, 1, 8'h03, 1, 1, 3'd0, 0, 0, 0, "F_stop");
`else
    step(D1, 0, 0, 8'h03, 1, 1, 3'd1, 0, 1, 0, "F_scan");
    finish_pass(D1, 3'd0, 8'h03, 1, "F");
`endif

    // Single channel at the top index, DWELL=1.
    step(D1, 1, 0, 8'h80, 1, 1, 3'd7, 0, 1, 0, "G_start");
    finish_pass(D1, 3'd7, 8'h80, 0, "G");

    repeat (4) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
